// File: rtl/matrix_mult_seq_rect_pkg.sv
// Shared definitions for the sequential rectangular matrix multiplier:
// counter sizing, FSM encoding and packed-element slice arithmetic.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // ceil(log2(value)), never less than 1 so a dimension of 1 still gets a bit
    function automatic int clog2_min1(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int elem_lsb(input int m, input int ncols, input int row, input int col);
        return m * (ncols * row + col);
    endfunction

endpackage

// File: rtl/matrix_mult_seq_rect_if.sv
// Start/busy/done handshake plus the packed operand and result buses.
interface matrix_mult_seq_rect_if #(
    parameter int ROWS  = 3,
    parameter int INNER = 3,
    parameter int COLS  = 3,
    parameter int M     = 32
);
    logic                      start;
    logic [M*ROWS*INNER-1:0]   x;
    logic [M*INNER*COLS-1:0]   y;
    logic                      busy;
    logic                      done;
    logic [M*ROWS*COLS-1:0]    o;

    modport master (output start, x, y, input busy, done, o);
    modport slave  (input start, x, y, output busy, done, o);
endinterface

// File: rtl/matrix_mult_seq_rect_mac_cell.sv
// One multiply-accumulate lane: M-bit truncated product added to a running sum.
// o_sum_next is the combinational sum+p used for the result write-back.
module mac_cell #(
    parameter int M      = 32,
    parameter int SIGNED = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [M-1:0] i_a,
    input  logic [M-1:0] i_b,
    input  logic         i_clear,
    input  logic         i_acc_en,
    output logic [M-1:0] o_sum_next
);
    logic [M-1:0] r_sum;
    logic [M-1:0] w_prod;

    generate
        if (SIGNED != 0) begin : g_signed
            assign w_prod = $signed(i_a) * $signed(i_b);
        end else begin : g_unsigned
            assign w_prod = i_a * i_b;
        end
    endgenerate

    assign o_sum_next = r_sum + w_prod;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (i_clear) begin
            r_sum <= '0;
        end else if (i_acc_en) begin
            r_sum <= o_sum_next;
        end
    end

endmodule

// File: rtl/matrix_mult_seq_rect.sv
// Sequential O = X * Y engine: one MAC per clock, walking O in row-major order
// with a start/busy/done handshake.
module matrix_mult_seq_rect
    import matrix_mult_pkg::*;
#(
    parameter int ROWS   = 3,
    parameter int INNER  = 3,
    parameter int COLS   = 3,
    parameter int M      = 32,
    parameter int SIGNED = 0
) (
    input logic clk,
    input logic rst,
    matrix_mult_seq_rect_if.slave mm_if
);
    localparam int IW = clog2_min1(ROWS);
    localparam int JW = clog2_min1(COLS);
    localparam int KW = clog2_min1(INNER);

    state_e         r_state;
    state_e         w_state_next;
    logic           r_busy;
    logic           r_done;
    logic [IW-1:0]  r_i;
    logic [JW-1:0]  r_j;
    logic [KW-1:0]  r_k;
    logic [M-1:0]   w_a;
    logic [M-1:0]   w_b;
    logic [M-1:0]   w_sum_next;
    logic [M*ROWS*COLS-1:0] r_o;

    logic w_k_last, w_j_last, w_i_last, w_last;
    logic w_accept, w_run;

    assign w_k_last = (r_k == KW'(INNER - 1));
    assign w_j_last = (r_j == JW'(COLS - 1));
    assign w_i_last = (r_i == IW'(ROWS - 1));
    assign w_last   = w_k_last && w_j_last && w_i_last;
    assign w_accept = (r_state == ST_IDLE) && mm_if.start;
    assign w_run    = (r_state == ST_RUN);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (mm_if.start) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)      w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next == ST_RUN);
            r_done  <= (w_state_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_accept) begin
            r_i <= '0;
            r_j <= '0;
            r_k <= '0;
        end else if (w_run) begin
            if (!w_k_last) begin
                r_k <= r_k + KW'(1);
            end else begin
                r_k <= '0;
                if (w_j_last) begin
                    r_j <= '0;
                    r_i <= w_i_last ? '0 : r_i + IW'(1);
                end else begin
                    r_j <= r_j + JW'(1);
                end
            end
        end
    end

    // Operand muxes: select X(i,k) and Y(k,j) from the packed input buses
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < INNER; c++)
                if (r_i == IW'(r) && r_k == KW'(c))
                    w_a = mm_if.x[elem_lsb(M, INNER, r, c) +: M];
        for (int r = 0; r < INNER; r++)
            for (int c = 0; c < COLS; c++)
                if (r_k == KW'(r) && r_j == JW'(c))
                    w_b = mm_if.y[elem_lsb(M, COLS, r, c) +: M];
    end

    mac_cell #(
        .M      (M),
        .SIGNED (SIGNED)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .i_a        (w_a),
        .i_b        (w_b),
        .i_clear    (w_accept || (w_run && w_k_last)),
        .i_acc_en   (w_run && !w_k_last),
        .o_sum_next (w_sum_next)
    );

    // NOTE: the result array is reset because o is architecturally visible and must read 0 after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_o <= '0;
        end else if (w_run && w_k_last) begin
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    if (r_i == IW'(r) && r_j == JW'(c))
                        r_o[elem_lsb(M, COLS, r, c) +: M] <= w_sum_next;
        end
    end

    assign mm_if.busy = r_busy;
    assign mm_if.done = r_done;
    assign mm_if.o    = r_o;

endmodule

// File: tb/tb_matrix_mult_seq_rect.sv
// Directed bench for matrix_mult_seq_rect: several parameterisations run side by
// side on one clock, with hand-computed products, latencies and busy widths.
module tb_matrix_mult_seq_rect;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] start_v = '0;
    logic [5:0] busy_v;
    logic [5:0] done_v;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    // a: 2x2x2 unsigned, b: 2x3x1, c: 1x2x1 signed, d: 1x2x1 unsigned, e: 1x1x1, f: 3x3x3
    matrix_mult_seq_rect_if #(.ROWS(2), .INNER(2), .COLS(2), .M(8)) if_a ();
    matrix_mult_seq_rect_if #(.ROWS(2), .INNER(3), .COLS(1), .M(8)) if_b ();
    matrix_mult_seq_rect_if #(.ROWS(1), .INNER(2), .COLS(1), .M(8)) if_c ();
    matrix_mult_seq_rect_if #(.ROWS(1), .INNER(2), .COLS(1), .M(8)) if_d ();
    matrix_mult_seq_rect_if #(.ROWS(1), .INNER(1), .COLS(1), .M(8)) if_e ();
    matrix_mult_seq_rect_if #(.ROWS(3), .INNER(3), .COLS(3), .M(8)) if_f ();

    matrix_mult_seq_rect #(.ROWS(2), .INNER(2), .COLS(2), .M(8), .SIGNED(0)) dut_a (.clk(clk), .rst(rst), .mm_if(if_a.slave));
    matrix_mult_seq_rect #(.ROWS(2), .INNER(3), .COLS(1), .M(8), .SIGNED(0)) dut_b (.clk(clk), .rst(rst), .mm_if(if_b.slave));
    matrix_mult_seq_rect #(.ROWS(1), .INNER(2), .COLS(1), .M(8), .SIGNED(1)) dut_c (.clk(clk), .rst(rst), .mm_if(if_c.slave));
    matrix_mult_seq_rect #(.ROWS(1), .INNER(2), .COLS(1), .M(8), .SIGNED(0)) dut_d (.clk(clk), .rst(rst), .mm_if(if_d.slave));
    matrix_mult_seq_rect #(.ROWS(1), .INNER(1), .COLS(1), .M(8), .SIGNED(0)) dut_e (.clk(clk), .rst(rst), .mm_if(if_e.slave));
    matrix_mult_seq_rect #(.ROWS(3), .INNER(3), .COLS(3), .M(8), .SIGNED(0)) dut_f (.clk(clk), .rst(rst), .mm_if(if_f.slave));

    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_d.start = start_v[3];
    assign if_e.start = start_v[4];
    assign if_f.start = start_v[5];
    assign busy_v = {if_f.busy, if_e.busy, if_d.busy, if_c.busy, if_b.busy, if_a.busy};
    assign done_v = {if_f.done, if_e.done, if_d.done, if_c.done, if_b.done, if_a.done};

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Start DUT n, optionally re-pulse start mid-run, measure edges until done and busy width.
    task automatic run(input int n, input int pulse_at, output int lat, output int bcnt);
        @(negedge clk);
        start_v[n] = 1'b1;
        @(posedge clk);
        lat  = -1;
        bcnt = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (c == 0) start_v[n] = 1'b0;
            if (c == pulse_at) start_v[n] = 1'b1;
            if (c == pulse_at + 1) start_v[n] = 1'b0;
            if (busy_v[n]) bcnt++;
            if (done_v[n]) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_check(input string tag, input int n, input int pulse_at, input int exp_lat);
        int lat, bcnt;
        run(n, pulse_at, lat, bcnt);
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_busy_cycles"}, bcnt, exp_lat);
    endtask

    initial begin
        int dcnt;
        if_a.x = {8'd1, 8'd0, 8'd0, 8'd1};
        if_a.y = {8'd4, 8'd3, 8'd2, 8'd1};
        if_b.x = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        if_b.y = {8'd1, 8'd1, 8'd1};
        if_c.x = {8'd3, 8'hFF};
        if_c.y = {8'hFE, 8'd5};
        if_d.x = {8'd3, 8'hFF};
        if_d.y = {8'hFE, 8'd5};
        if_e.x = 8'd16;
        if_e.y = 8'd16;
        if_f.x = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        if_f.y = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", busy_v, 6'b0);
        check("reset_done", done_v, 6'b0);
        check("reset_o_a", if_a.o, 32'h0);
        check("reset_o_f", if_f.o, 72'h0);

        run_check("a_identity", 0, -1, 8);
        check("a_identity_o", if_a.o, {8'd4, 8'd3, 8'd2, 8'd1});
        if_a.x = {8'd4, 8'd3, 8'd2, 8'd1};
        if_a.y = {8'd8, 8'd7, 8'd6, 8'd5};
        run_check("a_general", 0, -1, 8);
        check("a_general_o", if_a.o, {8'd50, 8'd43, 8'd22, 8'd19});

        run_check("b_ones", 1, -1, 6);
        check("b_ones_o", if_b.o, {8'd15, 8'd6});
        if_b.y = {8'd3, 8'd2, 8'd1};
        run_check("b_ramp", 1, -1, 6);
        check("b_ramp_o", if_b.o, {8'd32, 8'd14});

        run_check("c_signed", 2, -1, 2);
        check("c_signed_o", if_c.o, 8'hF5);
        run_check("d_unsigned", 3, -1, 2);
        check("d_unsigned_o", if_d.o, 8'hF5);

        run_check("e_wrap", 4, -1, 1);
        check("e_wrap_o", if_e.o, 8'h00);
        if_e.x = 8'd3;
        if_e.y = 8'd5;
        run_check("e_back_to_back", 4, -1, 1);
        check("e_back_to_back_o", if_e.o, 8'd15);

        run_check("f_midrun_start", 5, 10, 27);
        check("f_midrun_start_o", if_f.o,
              {8'd90, 8'd114, 8'd138, 8'd54, 8'd69, 8'd84, 8'd18, 8'd24, 8'd30});
        repeat (3) @(negedge clk);
        check("f_no_queued_run", busy_v[5], 1'b0);

        @(negedge clk);
        start_v[5] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[5] = 1'b0;
        repeat (4) @(negedge clk);
        check("f_busy_before_abort", busy_v[5], 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("f_abort_o", if_f.o, 72'h0);
        check("f_abort_busy", busy_v[5], 1'b0);
        check("f_abort_done", done_v[5], 1'b0);
        rst = 1'b0;
        dcnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_v[5] || busy_v[5]) dcnt++;
        end
        check("f_abort_no_done", dcnt, 0);

        run_check("f_after_abort", 5, -1, 27);
        check("f_after_abort_o", if_f.o,
              {8'd90, 8'd114, 8'd138, 8'd54, 8'd69, 8'd84, 8'd18, 8'd24, 8'd30});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
